// File: rtl/noc_pkg.sv
// ----------------------------------------------------------------------------
// Module : noc_pkg
// Shared router constants: port count, port indices and port mask type.
// Rev    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package noc_pkg;

  localparam int N_PORTS = 5;

  localparam int P_LOCAL = 0;
  localparam int P_NORTH = 1;
  localparam int P_EAST  = 2;
  localparam int P_SOUTH = 3;
  localparam int P_WEST  = 4;

  typedef logic [N_PORTS-1:0] port_mask_t;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ----------------------------------------------------------------------------
// Module : rr_pick
// Combinational round-robin pick: the search starts just above ptr and wraps.
// Rev    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_pick
  import noc_pkg::*;
#(
  parameter int N = N_PORTS,
  parameter int W = 3
) (
  input  logic [N-1:0] mask,
  input  logic [W-1:0] ptr,
  output logic         any,
  output logic [N-1:0] onehot,
  output logic [W-1:0] idx
);

  localparam logic [W:0] c_n = (W+1)'(N);

  logic [2*N-1:0] w_dbl;
  logic [W:0]     w_shamt;
  logic [N-1:0]   w_rot;
  logic [W:0]     w_off;
  logic [W:0]     w_sum;
  logic [W-1:0]   w_idx;

  // Rotate so that bit 0 of w_rot is the input at ptr+1.
  assign w_dbl   = {mask, mask};
  assign w_shamt = {1'b0, ptr} + (W+1)'(1);
  assign w_rot   = N'(w_dbl >> w_shamt);

  always_comb begin
    w_off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off = (W+1)'(k);
      end
    end
  end

  assign w_sum  = w_shamt + w_off;
  assign w_idx  = W'((w_sum >= c_n) ? (w_sum - c_n) : w_sum);

  assign any    = |mask;
  assign idx    = any ? w_idx : '0;
  assign onehot = any ? (N'(1) << w_idx) : '0;

endmodule

`default_nettype wire

// File: rtl/output_port_arbiter_rr.sv
// ----------------------------------------------------------------------------
// Module : output_port_arbiter_rr
// Round-robin wormhole arbiter for one router output port; the winner holds
// the port until its tail flit transfers.
// Rev    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module output_port_arbiter_rr
  import noc_pkg::*;
#(
  parameter int N_IN  = N_PORTS,
  parameter int IDX_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_IN-1:0]   req,
  input  logic [N_IN-1:0]   tail,
  input  logic              out_ready,
  output logic [N_IN-1:0]   grant,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              out_valid,
  output logic              fire,
  output logic              busy
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_LOCK = 1'b1;

  logic [0:0]       r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [N_IN-1:0]  r_grant;
  logic [IDX_W-1:0] r_grant_idx;

  logic [N_IN-1:0]  w_mask;
  logic             w_any;
  logic [N_IN-1:0]  w_onehot;
  logic [IDX_W-1:0] w_idx;
  logic             w_valid;
  logic             w_fire;
  logic             w_tail_fire;

  assign w_valid     = |(r_grant & req);
  assign w_fire      = w_valid & out_ready;
  assign w_tail_fire = w_fire & (|(r_grant & tail));

  // The releasing input is excluded so it cannot re-win in its own tail cycle.
  assign w_mask = (r_state == S_IDLE) ? req : (req & ~r_grant);

  rr_pick #(
    .N (N_IN),
    .W (IDX_W)
  ) u_pick (
    .mask   (w_mask),
    .ptr    (r_ptr),
    .any    (w_any),
    .onehot (w_onehot),
    .idx    (w_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= IDX_W'(N_IN - 1);
      r_grant     <= '0;
      r_grant_idx <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state     <= S_LOCK;
            r_grant     <= w_onehot;
            r_grant_idx <= w_idx;
            r_ptr       <= w_idx;
          end
        end
        S_LOCK: begin
          if (w_tail_fire) begin
            if (w_any) begin
              r_grant     <= w_onehot;
              r_grant_idx <= w_idx;
              r_ptr       <= w_idx;
            end else begin
              r_state     <= S_IDLE;
              r_grant     <= '0;
              r_grant_idx <= '0;
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_grant     <= '0;
          r_grant_idx <= '0;
        end
      endcase
    end
  end

  assign grant     = r_grant;
  assign grant_idx = r_grant_idx;
  assign out_valid = w_valid;
  assign fire      = w_fire;
  assign busy      = (r_state == S_LOCK);

  a_grant_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(r_grant));

endmodule

`default_nettype wire
